// File: rtl/riot_uart_tx.sv
// riot_uart_tx: buffered UART transmitter, valid/ready byte input, FIFO queue, LSB-first 8N1 output.
// Define RIOT_UART_PARITY_EN to insert one even-parity bit after the data bits (8E1 framing).
module riot_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef RIOT_UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             bit_done;

    logic [2:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign head       = mem[rd_ptr[ADDR_W-1:0]];

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign bit_done = (clk_cnt == CNT_LAST);
    assign pop      = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
    assign busy     = (state != S_IDLE) || !fifo_empty;

    // NOTE: FIFO storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef RIOT_UART_PARITY_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity <= 1'b0;
        end else if (pop) begin
            parity <= ^head;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift   <= head;
                        uart_tx <= 1'b0;
                        clk_cnt <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        uart_tx <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef RIOT_UART_PARITY_EN
                            uart_tx <= parity;
                            state   <= S_PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= S_STOP;
`endif
                        end else begin
                            uart_tx <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef RIOT_UART_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        uart_tx <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        // Back-to-back: next start bit follows the stop bit with no idle gap.
                        if (pop) begin
                            shift   <= head;
                            uart_tx <= 1'b0;
                            state   <= S_START;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end
endmodule
